// File: rtl/ita_div_dispatcher.sv
// Round-robin dispatcher for NUM_DIV serial dividers with strictly in-order
// retirement; request and result paths are pure combinational pass-through.
module ita_div_dispatcher #(
    parameter int unsigned NUM_DIV   = 4,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DIV_WIDTH-1:0]           in_divisor_i,
    input  logic [TAG_WIDTH-1:0]           in_tag_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DIV_WIDTH-1:0]           out_quot_o,
    output logic [TAG_WIDTH-1:0]           out_tag_o,
    output logic [NUM_DIV-1:0]             div_valid_o,
    input  logic [NUM_DIV-1:0]             div_ready_i,
    output logic [DIV_WIDTH-1:0]           div_op_b_o,
    input  logic [NUM_DIV-1:0]             div_valid_i,
    output logic [NUM_DIV-1:0]             div_ready_o,
    input  logic [NUM_DIV*DIV_WIDTH-1:0]   div_res_i,
    output logic                           div_flush_o,
    output logic                           idle_o,
    output logic [$clog2(NUM_DIV+1)-1:0]   occupancy_o
);

    localparam int unsigned PW = $clog2(NUM_DIV);
    localparam int unsigned CW = $clog2(NUM_DIV + 1);

    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [CW-1:0]        cnt;
    logic [TAG_WIDTH-1:0] tag_q [NUM_DIV];
    logic [DIV_WIDTH-1:0] res   [NUM_DIV];

    logic halt;
    logic not_empty;
    logic accept;
    logic retire;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(NUM_DIV - 1)) ? '0 : p + 1'b1;
    endfunction

    assign halt      = rst_i | flush_i;
    assign not_empty = (cnt != '0);

    // Fullness is judged on the registered count, so a retire in the full
    // cycle only reopens acceptance on the following cycle.
    assign in_ready_o  = !halt && (cnt < CW'(NUM_DIV)) && div_ready_i[wptr];
    assign accept      = in_valid_i & in_ready_o;

    assign out_valid_o = !halt && not_empty && div_valid_i[rptr];
    assign retire      = out_valid_o & out_ready_i;

    assign div_op_b_o  = in_divisor_i;
    assign div_flush_o = halt;
    assign idle_o      = !not_empty;
    assign occupancy_o = cnt;

    always_comb begin
        for (int unsigned i = 0; i < NUM_DIV; i++) begin
            res[i] = div_res_i[i*DIV_WIDTH +: DIV_WIDTH];
        end
    end

    assign out_quot_o = res[rptr];
    assign out_tag_o  = tag_q[rptr];

    // Only the slot under each pointer is ever strobed; results waiting on
    // other slots stay unacknowledged inside their divider.
    always_comb begin
        div_valid_o = '0;
        div_ready_o = '0;
        for (int unsigned i = 0; i < NUM_DIV; i++) begin
            div_valid_o[i] = accept && (wptr == PW'(i));
            div_ready_o[i] = out_ready_i && not_empty && !halt && (rptr == PW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (halt) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            if (rst_i) begin
                for (int unsigned i = 0; i < NUM_DIV; i++) begin
                    tag_q[i] <= '0;
                end
            end
        end else begin
            if (accept) begin
                tag_q[wptr] <= in_tag_i;
                wptr        <= ptr_next(wptr);
            end
            if (retire) begin
                rptr <= ptr_next(rptr);
            end
            case ({accept, retire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ita_div_dispatcher.sv
// Self-checking bench: behavioural divider slots plus an in-order request
// queue model; directed scenarios followed by a randomized phase.
`timescale 1ns/1ps
module tb_ita_div_dispatcher;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst_i, flush_i, in_valid_i, out_ready_i;
    logic            in_ready_o, out_valid_o, div_flush_o, idle_o;
    logic [DW-1:0]   in_divisor_i, out_quot_o, div_op_b_o;
    logic [TW-1:0]   in_tag_i, out_tag_o;
    logic [N-1:0]    div_valid_o, div_ready_i, div_valid_i, div_ready_o;
    logic [N*DW-1:0] div_res_i;
    logic [2:0]      occupancy_o;

    ita_div_dispatcher #(.NUM_DIV(N), .DIV_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_divisor_i(in_divisor_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_quot_o(out_quot_o), .out_tag_o(out_tag_o),
        .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
        .div_op_b_o(div_op_b_o), .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o), .div_res_i(div_res_i),
        .div_flush_o(div_flush_o), .idle_o(idle_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    // Behavioural serial dividers: fixed numerator, per-request latency.
    logic          env_busy [N];
    int            env_cd   [N];
    logic [DW-1:0] env_res  [N];
    int            lat_cfg;

    function automatic logic [DW-1:0] quot_of(input logic [DW-1:0] d);
        logic [31:0] q;
        q = (d == '0) ? 32'h00FF_FFFF : 32'h0000_FFFF / {8'h00, d};
        return q[DW-1:0];
    endfunction

    initial for (int i = 0; i < N; i++) begin
        env_busy[i] = 1'b0; env_cd[i] = 0; env_res[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (div_flush_o) env_busy[i] <= 1'b0;
            else if (div_valid_o[i]) begin
                env_busy[i] <= 1'b1;
                env_cd[i]   <= lat_cfg;
                env_res[i]  <= quot_of(div_op_b_o);
            end else if (env_busy[i] && env_cd[i] == 0 && div_ready_o[i]) env_busy[i] <= 1'b0;
            else if (env_busy[i] && env_cd[i] > 0) env_cd[i] <= env_cd[i] - 1;
        end
    end

    always_comb begin
        div_ready_i = '0;
        div_valid_i = '0;
        div_res_i   = '0;
        for (int i = 0; i < N; i++) begin
            div_ready_i[i] = !env_busy[i];
            div_valid_i[i] = env_busy[i] && (env_cd[i] == 0);
            div_res_i[i*DW +: DW] = env_res[i];
        end
    end

    // Reference model: requests in issue order; request k after a flush uses slot k mod N.
    typedef struct { logic [DW-1:0] quot; logic [TW-1:0] tag; } req_t;
    req_t q[$];
    int   wslot = 0, rslot = 0;
    int   errors = 0, checks = 0;
    bit   last_acc;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        bit halt, er, eov, ret;
        logic [N-1:0] edv, edr;
        @(negedge clk);
        halt = rst_i || flush_i;
        er   = !halt && q.size() < N && !env_busy[wslot];
        eov  = !halt && q.size() > 0 && env_busy[rslot] && env_cd[rslot] == 0;
        ret  = eov && out_ready_i;
        edv  = (er && in_valid_i) ? N'(1) << wslot : '0;
        edr  = (!halt && out_ready_i && q.size() > 0) ? N'(1) << rslot : '0;
        chk("in_ready",    32'(in_ready_o),  32'(er));
        chk("out_valid",   32'(out_valid_o), 32'(eov));
        chk("div_valid",   32'(div_valid_o), 32'(edv));
        chk("div_ready",   32'(div_ready_o), 32'(edr));
        chk("div_flush",   32'(div_flush_o), 32'(halt));
        chk("idle",        32'(idle_o),      32'(q.size() == 0));
        chk("occupancy",   32'(occupancy_o), 32'(q.size()));
        chk("div_op_b",    32'(div_op_b_o),  32'(in_divisor_i));
        if (eov) begin
            chk("out_quot", 32'(out_quot_o), 32'(q[0].quot));
            chk("out_tag",  32'(out_tag_o),  32'(q[0].tag));
        end
        last_acc = er && in_valid_i;
        @(posedge clk);
        if (halt) begin
            q.delete(); wslot = 0; rslot = 0;
        end else begin
            if (ret) begin void'(q.pop_front()); rslot = (rslot + 1) % N; end
            if (last_acc) begin
                q.push_back('{quot: quot_of(in_divisor_i), tag: in_tag_i});
                wslot = (wslot + 1) % N;
            end
        end
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input int lat, input int bound);
        bit done = 0;
        in_valid_i = 1'b1; in_divisor_i = d; in_tag_i = t; lat_cfg = lat;
        for (int c = 0; c < bound && !done; c++) begin
            cycle();
            done = last_acc;
        end
        chk("send_accepted", 32'(done), 32'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input int bound);
        out_ready_i = 1'b1; in_valid_i = 1'b0;
        for (int c = 0; c < bound && q.size() != 0; c++) cycle();
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; cycle(); cycle(); rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        in_divisor_i = 24'h000100; in_tag_i = 6'd1; lat_cfg = 0;
        cycle(); cycle();
        rst_i = 1'b0; in_valid_i = 1'b0;

        // Single request through slot 0 with 24-cycle latency.
        out_ready_i = 1'b1;
        send(24'h000100, 6'd5, 24, 4);
        chk("single_occ", 32'(occupancy_o), 32'd1);
        drain(40);
        chk("single_quot_model", 32'(quot_of(24'h000100)), 32'h0000FF);
        chk("single_idle", 32'(idle_o), 32'd1);

        // Fill and stall.
        do_reset();
        out_ready_i = 1'b0;
        for (int t = 0; t < 4; t++) send(24'(t + 3), 6'(t), 2, 2);
        in_valid_i = 1'b1; in_divisor_i = 24'h0000AA; in_tag_i = 6'd4;
        for (int c = 0; c < 4; c++) cycle();
        chk("full_occ",   32'(occupancy_o), 32'd4);
        chk("full_ready", 32'(in_ready_o),  32'd0);
        out_ready_i = 1'b1;
        send(24'h0000AA, 6'd4, 2, 6);
        drain(40);

        // Reordering: slot 1 completes long before slot 0.
        do_reset();
        out_ready_i = 1'b1;
        send(24'h000123, 6'd0, 20, 2);
        send(24'h000456, 6'd1, 8, 2);
        drain(60);

        // Simultaneous accept and retire at two outstanding.
        do_reset();
        out_ready_i = 1'b0;
        send(24'h000011, 6'd10, 1, 2);
        send(24'h000022, 6'd11, 1, 2);
        for (int c = 0; c < 3; c++) cycle();
        out_ready_i = 1'b1;
        send(24'h000033, 6'd12, 1, 2);
        chk("sim_occ", 32'(occupancy_o), 32'd2);
        out_ready_i = 1'b0;
        // Back-pressure: result waiting, consumer stalled for 7 cycles.
        for (int c = 0; c < 7; c++) cycle();
        chk("bp_tag", 32'(out_tag_o), 32'd11);
        drain(40);

        // Flush, then reset, mid-operation.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            out_ready_i = 1'b0;
            for (int t = 0; t < 3; t++) send(24'(t + 40), 6'(t + 20), 30, 2);
            if (k == 0) flush_i = 1'b1; else rst_i = 1'b1;
            cycle();
            flush_i = 1'b0; rst_i = 1'b0;
            chk("post_flush_idle", 32'(idle_o), 32'd1);
            out_ready_i = 1'b1;
            send(24'h000200, 6'd9, 5, 2);
            drain(30);
        end

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid_i   = 1'($urandom_range(0, 1));
            out_ready_i  = ($urandom_range(0, 3) != 0);
            in_divisor_i = 24'($urandom_range(1, 32'hFFFF));
            in_tag_i     = 6'($urandom);
            lat_cfg      = $urandom_range(0, 15);
            flush_i      = ($urandom_range(0, 63) == 0);
            rst_i        = ($urandom_range(0, 127) == 0);
            cycle();
        end
        flush_i = 1'b0; rst_i = 1'b0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ita_div_dispatcher.md
Name: ita_div_dispatcher

Overview:
Shares the softmax block's NUM_DIV serial dividers between a single stream of normalisation requests. It dispatches each divisor round-robin to the next free divider slot and records a per-slot tag. Quotients are retired strictly in issue order, so the softmax streaming stage sees results in request order even when divider latencies differ. The block sits between the softmax controller's divider request/response ports and the serial divider instances.

Parameters:
NUM_DIV, 4, number of serial divider instances managed (≥2)
DIV_WIDTH, 24, divisor and quotient width
TAG_WIDTH, 6, width of the request tag (row/address counter)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  abort all in-flight divisions
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted this cycle when high with in_valid_i
in_divisor_i  in  DIV_WIDTH  divisor (accumulated exp sum)
in_tag_i  in  TAG_WIDTH  tag carried with the request
out_valid_o  out  1  in-order quotient available
out_ready_i  in  1  consumer accepts quotient
out_quot_o  out  DIV_WIDTH  quotient
out_tag_o  out  TAG_WIDTH  tag of out_quot_o
div_valid_o  out  NUM_DIV  per-divider operand valid
div_ready_i  in  NUM_DIV  per-divider operand ready
div_op_b_o  out  DIV_WIDTH  shared divisor bus, equals in_divisor_i
div_valid_i  in  NUM_DIV  per-divider result valid
div_ready_o  out  NUM_DIV  per-divider result ready
div_res_i  in  NUM_DIV*DIV_WIDTH  per-divider results, slot i at bits [i*DIV_WIDTH +: DIV_WIDTH]
div_flush_o  out  1  flush to all dividers
idle_o  out  1  no division outstanding
occupancy_o  out  $clog2(NUM_DIV+1)  number of outstanding divisions

Behaviour:
- State: dispatch pointer wptr, retire pointer rptr (both 0..NUM_DIV-1), outstanding count cnt (0..NUM_DIV), tag registers tag_q[NUM_DIV]. All are cleared to 0 on rst_i.
- Outputs during and after reset: in_ready_o=0 while rst_i is high; out_valid_o=0, div_valid_o=0, div_ready_o=0, idle_o=1, occupancy_o=0. div_flush_o is high.
- div_flush_o = rst_i | flush_i, combinational.
- Accept condition: in_ready_o = !rst_i & !flush_i & (cnt<NUM_DIV) & div_ready_i[wptr].
- Dispatch is combinational: div_valid_o[wptr] = in_valid_i & in_ready_o; all other div_valid_o bits are 0.
- On accept: tag_q[wptr] <= in_tag_i; wptr advances by one, wrapping NUM_DIV-1 → 0.
- Retire: out_valid_o = (cnt!=0) & div_valid_i[rptr] & !flush_i.
  - out_quot_o = div_res_i[rptr]; out_tag_o = tag_q[rptr].
  - div_ready_o[rptr] = out_ready_i & (cnt!=0) & !flush_i; all other div_ready_o bits are 0.
  - On handshake, rptr advances with the same wrap rule.
- Results arriving on slots other than rptr are held by their divider until that slot becomes rptr. No out-of-order retirement.
- Latency: zero-cycle pass-through on both the request and result paths. The block adds no pipeline register.
- cnt update: +1 on accept only, −1 on retire only, unchanged when both happen in the same cycle. Accept with cnt=NUM_DIV is impossible (in_ready_o=0). Retire with cnt=0 is impossible (out_valid_o=0).
- Full (cnt=NUM_DIV): wptr==rptr and in_ready_o=0. A same-cycle retire does not reopen acceptance until the next cycle.
- Empty (cnt=0): idle_o=1. A spurious div_valid_i is ignored and not acknowledged.
- flush_i, or rst_i mid-operation: at the next edge wptr, rptr and cnt return to 0; tags become don't-care. No handshake completes in the flush cycle. In-flight results are dropped via div_flush_o.
- rst_i has priority over flush_i; behaviour is identical for both.
- X-safety: out_quot_o and out_tag_o are don't-care while out_valid_o=0.

Test Plan:
- Single request: after reset, divisor 0x000100, tag 5, divider 0 returns 0x0000FF after 24 cycles → out_valid_o with quot 0x0000FF, tag 5; cnt goes 0→1→0; idle_o returns to 1.
- Fill and stall: 5 back-to-back requests (tags 0–4), out_ready_i=0 → slots 0–3 are accepted and in_ready_o drops on the 5th request. occupancy_o=4. Next accept goes to slot 0 only after slot 0 retires.
- Reordering: slot 1 finishes 10 cycles before slot 0 → output order remains tag0 then tag1. div_ready_o[1] stays 0 until tag0 is consumed.
- Simultaneous accept and retire at cnt=2: cnt stays 2; both wptr and rptr advance by one.
- Back-pressure: out_ready_i low for 7 cycles while div_valid_i[rptr]=1 → out_valid_o holds with stable quot and tag; no pointer moves.
- Flush mid-operation: 3 outstanding, pulse flush_i for 1 cycle → div_flush_o=1 that cycle, then cnt=0, idle_o=1. A new request with tag 9 goes to slot 0 and retires with tag 9. Repeat with rst_i pulsed mid-operation and require the same result.
